// File: rtl/serial_adder_unit.sv
// Bit-serial add/subtract: one full-adder cell with a registered carry walks the
// operands LSB-first, one bit per clock, behind valid/ready handshakes.

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_in_ready, r_cout, r_ovf;
  logic             w_s, w_co;

  full_adder_cell u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_co)
  );

  // in_ready is its own register so it stays low for the cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b ^ {WIDTH{sub}};
            r_carry    <= sub;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_co;
          if (r_cnt == LAST) begin
            // r_carry here is the carry into the MSB
            r_cout  <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed and randomized checks of serial_adder_unit at WIDTH=8.

module tb_serial_adder_unit;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_adder_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Drives one operation; returns captured result, latency in cycles, timeout flag.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input int stall, output logic [7:0] s, output logic c,
                       output logic o, output int lat, output bit tmo);
    int n;
    tmo = 0; s = '0; c = 0; o = 0; lat = 0; n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) begin tmo = 1; return; end
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (out_valid !== 1'b1) begin tmo = 1; return; end
    repeat (stall) begin @(posedge clk); #1; end
    s = sum; c = cout; o = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b sum=%h c=%b o=%b exp all 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic run_vectors(input string name, input logic [7:0] va[3], input logic [7:0] vb[3],
                             input logic vs[3], input logic [7:0] es[3], input logic ec[3],
                             input logic eo[3], input int nv);
    logic [7:0] s; logic c, o; int lat; bit tmo;
    for (int i = 0; i < nv; i++) begin
      do_op(va[i], vb[i], vs[i], 0, s, c, o, lat, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL %s_timeout vec %0d", name, i); end
      checks++;
      if ({s, c, o} !== {es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL %s vec %0d got sum=%h c=%b o=%b exp sum=%h c=%b o=%b",
                 name, i, s, c, o, es[i], ec[i], eo[i]);
      end
      checks++;
      if (lat !== W + 1) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, lat, W + 1); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after got %b exp 1", name, in_ready); end
    end
  endtask

  task automatic test_add();
    run_vectors("add", '{8'h3C, 8'hFF, 8'h00}, '{8'h5A, 8'h01, 8'h00}, '{1'b0, 1'b0, 1'b0},
                '{8'h96, 8'h00, 8'h00}, '{1'b0, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0}, 3);
  endtask

  task automatic test_sub();
    run_vectors("sub", '{8'h05, 8'h80, 8'h00}, '{8'h07, 8'h01, 8'h00}, '{1'b1, 1'b1, 1'b0},
                '{8'hFE, 8'h7F, 8'h00}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, 2);
  endtask

  task automatic test_backpressure();
    int n;
    a = 8'h3C; b = 8'h5A; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; sub = 1'b1;  // in_valid stays high: must be ignored
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got vld=%b exp 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 8'h96, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b sum=%h c=%b o=%b exp 1 0 96 0 1",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s; logic c, o; int lat, seen; bit tmo;
    a = 8'h12; b = 8'h34; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;       // accepted; 1st RUN cycle
    in_valid = 1'b0;
    @(posedge clk); #1;       // 2nd RUN cycle
    @(posedge clk); #1;       // 3rd RUN cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, sum} !== 10'h000) begin
      errors++; $display("FAIL midrst_outputs got rdy=%b vld=%b sum=%h exp 0 0 00", in_ready, out_valid, sum);
    end
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_result got %0d pulses exp 0", seen); end
    do_op(8'h01, 8'h02, 1'b0, 0, s, c, o, lat, tmo);
    checks++;
    if (tmo || {s, c, o} !== {8'h03, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst_next got sum=%h c=%b o=%b tmo=%b exp 03 0 0", s, c, o, tmo);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra, rb, s, es; logic rs, c, o, ec, eo; logic [8:0] e9;
    int lat, n_in, n_out, bad; bit tmo;
    n_in = 0; n_out = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      e9 = rs ? ({1'b0, ra} + {1'b0, ~rb} + 9'd1) : ({1'b0, ra} + {1'b0, rb});
      es = e9[7:0];
      ec = rs ? (ra >= rb) : e9[8];
      eo = rs ? ((ra[7] != rb[7]) && (es[7] != ra[7])) : ((ra[7] == rb[7]) && (es[7] != ra[7]));
      n_in++;
      do_op(ra, rb, rs, int'($urandom_range(0, 3)), s, c, o, lat, tmo);
      if (!tmo) n_out++;
      checks++;
      if (tmo || {s, c, o} !== {es, ec, eo}) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand op %0d %h %s %h got sum=%h c=%b o=%b exp sum=%h c=%b o=%b tmo=%b",
                   i, ra, rs ? "-" : "+", rb, s, c, o, es, ec, eo, tmo);
        bad++;
      end
    end
    checks++;
    if (n_out !== n_in) begin errors++; $display("FAIL rand_count got %0d exp %0d", n_out, n_in); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
